// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Stateful hazard controller for the 5-stage MIPS pipeline. It drives the flush
// and stall enables of the IF/ID, ID/EX and EX/MEM latches and the PC.
//
// Hazards handled:
//   - taken branch        : flush IF/ID, ID/EX and EX/MEM
//   - jump/jalr in EX/MEM : bubble into ID/EX only
//   - HALT in MEM/WB      : drain the pipeline, then hold it until resumed
//   - load-use            : LOAD_LAT bubbles while PC and IF/ID are held
//
// The block also keeps a saturating count of PC-stall cycles for the debug
// unit. The count excludes cycles spent parked in HALTED.
//
// Parameters:
//   REGS     register-address width
//   LOAD_LAT load-use bubbles inserted per hazard (1..15)
//   CNT_W    width of the stall-cycle counter
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_ID_EX_rt             destination register of the instruction in EX
//   i_ID_EX_mem_read       instruction in EX is a load
//   i_IF_ID_rs/_rt         source registers of the instruction in ID
//   i_IF_ID_uses_rt        ID instruction actually reads rt
//   i_branch_taken         branch resolved taken
//   i_EX/MEM_jump_or_jalr  jump or jalr in EX / MEM
//   i_MEM_halt, i_WB_halt  HALT in MEM / WB
//   i_resume               debug unit restarts the pipeline after a halt
//   o_flush_IF_ID          flush IF/ID latch
//   o_flush_ID             insert a bubble into ID/EX
//   o_flush_EX_MEM         flush EX/MEM latch
//   o_stall_IF_ID          hold IF/ID latch
//   o_stall_pc             hold PC
//   o_halted               pipeline halted (registered)
//   o_stall_cycles         PC-stall cycle count (registered, saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
  parameter int REGS     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [REGS-1:0]  i_ID_EX_rt,
  input  logic             i_ID_EX_mem_read,
  input  logic [REGS-1:0]  i_IF_ID_rs,
  input  logic [REGS-1:0]  i_IF_ID_rt,
  input  logic             i_IF_ID_uses_rt,
  input  logic             i_branch_taken,
  input  logic             i_EX_jump_or_jalr,
  input  logic             i_MEM_jump_or_jalr,
  input  logic             i_MEM_halt,
  input  logic             i_WB_halt,
  input  logic             i_resume,
  output logic             o_flush_IF_ID,
  output logic             o_flush_ID,
  output logic             o_flush_EX_MEM,
  output logic             o_stall_IF_ID,
  output logic             o_stall_pc,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } state_t;

  // Remaining bubbles fit in 4 bits because LOAD_LAT is limited to 15.
  localparam logic [3:0] LAT = 4'(LOAD_LAT);

  state_t     state, state_next;
  logic [3:0] load_cnt, load_cnt_next;

  logic load_use;
  logic halt_req;
  logic jump_req;

  // Register $0 is hard-wired to zero, so a load targeting it never creates
  // a real dependency.
  assign load_use = i_ID_EX_mem_read && (i_ID_EX_rt != '0) &&
                    ((i_ID_EX_rt == i_IF_ID_rs) ||
                     ((i_ID_EX_rt == i_IF_ID_rt) && i_IF_ID_uses_rt));

  assign halt_req = i_MEM_halt || i_WB_halt;
  assign jump_req = i_EX_jump_or_jalr || i_MEM_jump_or_jalr;

  // Next-state and output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    state_next     = state;
    load_cnt_next  = load_cnt;
    o_flush_IF_ID  = 1'b0;
    o_flush_ID     = 1'b0;
    o_flush_EX_MEM = 1'b0;
    o_stall_IF_ID  = 1'b0;
    o_stall_pc     = 1'b0;

    unique case (state)
      RUN: begin
        if (i_branch_taken) begin
          o_flush_IF_ID  = 1'b1;
          o_flush_ID     = 1'b1;
          o_flush_EX_MEM = 1'b1;
        end else if (jump_req) begin
          o_flush_ID = 1'b1;
        end else if (halt_req) begin
          o_flush_IF_ID  = 1'b1;
          o_flush_ID     = 1'b1;
          o_flush_EX_MEM = 1'b1;
          o_stall_pc     = 1'b1;
          // HALT already in WB means nothing younger is left to drain.
          state_next     = i_WB_halt ? HALTED : HALT_DRAIN;
        end else if (load_use) begin
          o_flush_ID    = 1'b1;
          o_stall_IF_ID = 1'b1;
          o_stall_pc    = 1'b1;
          // This cycle is the first bubble; LOAD_STALL supplies the rest.
          if (LOAD_LAT > 1) begin
            state_next    = LOAD_STALL;
            load_cnt_next = LAT - 4'd1;
          end
        end
      end

      LOAD_STALL: begin
        if (i_branch_taken) begin
          o_flush_IF_ID  = 1'b1;
          o_flush_ID     = 1'b1;
          o_flush_EX_MEM = 1'b1;
          state_next     = RUN;
          load_cnt_next  = 4'd0;
        end else if (halt_req) begin
          o_flush_IF_ID  = 1'b1;
          o_flush_ID     = 1'b1;
          o_flush_EX_MEM = 1'b1;
          o_stall_pc     = 1'b1;
          state_next     = i_WB_halt ? HALTED : HALT_DRAIN;
          load_cnt_next  = 4'd0;
        end else begin
          o_flush_ID    = 1'b1;
          o_stall_IF_ID = 1'b1;
          o_stall_pc    = 1'b1;
          if (load_cnt <= 4'd1) begin
            state_next    = RUN;
            load_cnt_next = 4'd0;
          end else begin
            load_cnt_next = load_cnt - 4'd1;
          end
        end
      end

      HALT_DRAIN: begin
        o_flush_IF_ID  = 1'b1;
        o_flush_ID     = 1'b1;
        o_flush_EX_MEM = 1'b1;
        o_stall_pc     = 1'b1;
        if (i_WB_halt) begin
          state_next = HALTED;
        end
      end

      HALTED: begin
        o_flush_IF_ID  = 1'b1;
        o_flush_ID     = 1'b1;
        o_flush_EX_MEM = 1'b1;
        o_stall_IF_ID  = 1'b1;
        o_stall_pc     = 1'b1;
        if (i_resume) begin
          state_next = RUN;
        end
      end

      default: begin
        state_next    = RUN;
        load_cnt_next = 4'd0;
      end
    endcase

    // Reset silences every enable immediately, not just from the next edge.
    if (i_reset) begin
      o_flush_IF_ID  = 1'b0;
      o_flush_ID     = 1'b0;
      o_flush_EX_MEM = 1'b0;
      o_stall_IF_ID  = 1'b0;
      o_stall_pc     = 1'b0;
    end
  end

  // State, bubble counter and halted flag.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    if (i_reset) begin
      state    <= RUN;
      load_cnt <= 4'd0;
      o_halted <= 1'b0;
    end else begin
      state    <= state_next;
      load_cnt <= load_cnt_next;
      o_halted <= (state_next == HALTED);
    end
  end

  // Saturating PC-stall counter; parked HALTED cycles are not counted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_cycles <= '0;
    end else if (o_stall_pc && (state != HALTED) && (o_stall_cycles != '1)) begin
      o_stall_cycles <= o_stall_cycles + CNT_W'(1);
    end
  end

endmodule
